// File: rtl/mux_4_input_pkg.sv
// Shared select codes and default data width for the 4:1 datapath word multiplexer.
package mux_4_input_pkg;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  localparam int unsigned DEFAULT_WIDTH = 16;

endpackage

// File: rtl/mux_4_input_if.sv
// Data/select bundle for mux_4_input; master drives the data words and select,
// slave returns the combinational and registered selection.
interface mux_4_input_if
  import mux_4_input_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       ctrl;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;

  modport master (
    output a,
    output b,
    output c,
    output d,
    output ctrl,
    input  out,
    input  out_q
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    input  d,
    input  ctrl,
    output out,
    output out_q
  );

endinterface

// File: rtl/mux_4_input.sv
// 4:1 word multiplexer: combinational selection on out, plus a one-cycle registered
// copy on out_q that is cleared asynchronously by rst_n.
module mux_4_input
  import mux_4_input_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_4_input_if.slave  bus
);

  logic [WIDTH-1:0] sel_d;
  logic [WIDTH-1:0] sel_q;

  // An unknown select propagates X rather than silently falling back to a.
  always_comb begin
    sel_d = 'x;
    case (bus.ctrl)
      SEL_A:   sel_d = bus.a;
      SEL_B:   sel_d = bus.b;
      SEL_C:   sel_d = bus.c;
      SEL_D:   sel_d = bus.d;
      default: sel_d = 'x;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign bus.out   = sel_d;
  assign bus.out_q = sel_q;

endmodule

// File: tb/tb_mux_4_input.sv
// Scoreboard bench for mux_4_input: stimulus queues expected words, a monitor
// samples the DUT on each sample event and compares.
module tb_mux_4_input;

  localparam int unsigned W = 16;

  typedef struct {
    string      name;
    bit         reg_out;  // 0: out, 1: out_q
    bit         neq;      // expect inequality instead of equality
    logic [W-1:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  event sample_ev;
  int   checks;
  int   fails;

  mux_4_input_if #(.WIDTH(W)) bus ();

  mux_4_input #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  // Monitor: drains every pending expectation against the DUT outputs at the sample point.
  always @(sample_ev) begin
    while (sb.size() > 0) begin
      exp_t         it;
      logic [W-1:0] act;
      bit           ok;
      it  = sb.pop_front();
      act = it.reg_out ? bus.out_q : bus.out;
      ok  = it.neq ? (act !== it.val) : (act === it.val);
      checks++;
      if (!ok) begin
        fails++;
        $display("FAIL %s: got %h, required %s%h", it.name, act, it.neq ? "not " : "", it.val);
      end
    end
  end

  task automatic expect_word(input string name, input bit reg_out, input bit neq,
                             input logic [W-1:0] val);
    exp_t it;
    it.name    = name;
    it.reg_out = reg_out;
    it.neq     = neq;
    it.val     = val;
    sb.push_back(it);
  endtask

  task automatic sample();
    -> sample_ev;
    #0;
  endtask

  logic [W-1:0] sw_tbl [5];
  logic [1:0]   sw_ctl [5];

  initial begin
    logic [W-1:0] ea, eb, ec, ed, exp_v;
    checks = 0;
    fails  = 0;
    sw_tbl = '{16'h0001, 16'h00FF, 16'hAAAA, 16'hFFFF, 16'h0001};
    sw_ctl = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset: out_q held at zero while out follows d.
    rst_n    = 1'b0;
    bus.ctrl = 2'd3;
    bus.a    = 16'd1;
    bus.b    = 16'd0;
    bus.c    = 16'd4;
    bus.d    = 16'd17;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_word("rst_out_q", 1'b1, 1'b0, 16'h0000);
    expect_word("rst_out",   1'b0, 1'b0, 16'd17);
    sample();
    rst_n = 1'b1;
    #1;
    expect_word("release_no_edge_out_q", 1'b1, 1'b0, 16'h0000);
    sample();
    @(posedge clk);
    #1;
    expect_word("first_edge_out_q", 1'b1, 1'b0, 16'd17);
    sample();
    // Mid-cycle reset clears out_q with no clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    expect_word("async_rst_out_q", 1'b1, 1'b0, 16'h0000);
    expect_word("async_rst_out",   1'b0, 1'b0, 16'd17);
    sample();
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational select sweeps: 16 values per channel.
    for (int sel = 0; sel < 4; sel++) begin
      ea = 16'd1;
      eb = 16'd0;
      ec = 16'd4;
      ed = 16'd17;
      bus.ctrl = 2'(sel);
      for (int step = 0; step < 16; step++) begin
        if (step > 0) begin
          ea = ea << 1;
          eb = eb + 16'd1;
          ec = ec + 16'd3;
          ed = ed + 16'd4;
        end
        bus.a = ea;
        bus.b = eb;
        bus.c = ec;
        bus.d = ed;
        #50;
        exp_v = (sel == 0) ? ea : (sel == 1) ? eb : (sel == 2) ? ec : ed;
        expect_word($sformatf("sel%0d_step%0d", sel, step), 1'b0, 1'b0, exp_v);
        if (sel == 3) expect_word($sformatf("d_ne_a_step%0d", step), 1'b0, 1'b1, ea);
        sample();
      end
    end

    // Select switching under fixed data: out same cycle, out_q one cycle later.
    bus.a = 16'h0001;
    bus.b = 16'h00FF;
    bus.c = 16'hAAAA;
    bus.d = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.ctrl = sw_ctl[i];
      #1;
      expect_word($sformatf("sw_out_%0d", i), 1'b0, 1'b0, sw_tbl[i]);
      if (i > 0) expect_word($sformatf("sw_out_q_%0d", i), 1'b1, 1'b0, sw_tbl[i-1]);
      sample();
    end

    for (int k = 0; k < 10 && sb.size() != 0; k++) #1;
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
